// File: rtl/timer_device.sv
// timer_device: 16-bit memory-mapped timer/counter on the shared 8-bit bus.
// Register map: 0 CTRL, 1 STATUS (W1C), 2/3 COUNT lo/hi, 4/5 CMP lo/hi.
// Optional one-shot auto-stop (CTRL bit2) is built when TIMER_ONESHOT_EN
// is defined; otherwise bit2 reads 0 and writes to it are ignored.
module timer_device #(
   parameter int unsigned PRESC_MAX_EXP = 15,
   parameter logic [15:0] CMP_RESET     = 16'hFFFF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] address,
   input  logic       enable,
   input  logic       mode,
   input  logic [7:0] data_in,
   output logic [7:0] data_out
);

   localparam logic [3:0] PRESC_MAX = 4'(PRESC_MAX_EXP);

   localparam logic [3:0] A_CTRL   = 4'h0;
   localparam logic [3:0] A_STATUS = 4'h1;
   localparam logic [3:0] A_CNT_LO = 4'h2;
   localparam logic [3:0] A_CNT_HI = 4'h3;
   localparam logic [3:0] A_CMP_LO = 4'h4;
   localparam logic [3:0] A_CMP_HI = 4'h5;

   logic        en_q, en_d;
   logic        reload_q, reload_d;
   logic [3:0]  presc_exp_q, presc_exp_d;
   logic        match_q, match_d;
   logic        wrap_q, wrap_d;
   logic [15:0] count_q, count_d;
   logic [15:0] cmp_q, cmp_d;
   logic [15:0] presc_q, presc_d;
   logic [7:0]  cnt_stage_q, cnt_stage_d;
   logic [7:0]  cmp_stage_q, cmp_stage_d;
   logic [7:0]  shadow_q, shadow_d;
`ifdef TIMER_ONESHOT_EN
   logic        oneshot_q, oneshot_d;
`endif

   logic        bus_wr, bus_rd;
   logic        wr_ctrl, wr_status, wr_cnt_lo, wr_cnt_hi, wr_cmp_lo, wr_cmp_hi;
   logic        rd_cnt_lo;
   logic [15:0] presc_lim;
   logic        tick, hit, wrap_evt;
   logic        oneshot_bit;
   logic [7:0]  rd_data;

   // Bus decode, prescaler tick and the compare/wrap events of this cycle
   always_comb begin
      bus_wr    = enable && mode;
      bus_rd    = enable && !mode;
      wr_ctrl   = bus_wr && (address == A_CTRL);
      wr_status = bus_wr && (address == A_STATUS);
      wr_cnt_lo = bus_wr && (address == A_CNT_LO);
      wr_cnt_hi = bus_wr && (address == A_CNT_HI);
      wr_cmp_lo = bus_wr && (address == A_CMP_LO);
      wr_cmp_hi = bus_wr && (address == A_CMP_HI);
      rd_cnt_lo = bus_rd && (address == A_CNT_LO);

      presc_lim = (16'd1 << presc_exp_q) - 16'd1;
      tick      = en_q && (presc_q == presc_lim);
      hit       = tick && (count_q == cmp_q);
      // A reload to zero is not a rollover, so it never raises WRAP
      wrap_evt  = tick && (count_q == 16'hFFFF) && !(hit && reload_q);
`ifdef TIMER_ONESHOT_EN
      oneshot_bit = oneshot_q;
`else
      oneshot_bit = 1'b0;
`endif
   end

   // Next-state logic for control, status, counter and staging registers
   always_comb begin
      en_d        = en_q;
      reload_d    = reload_q;
      presc_exp_d = presc_exp_q;
      cnt_stage_d = cnt_stage_q;
      cmp_stage_d = cmp_stage_q;
      cmp_d       = cmp_q;
      shadow_d    = shadow_q;
`ifdef TIMER_ONESHOT_EN
      oneshot_d   = oneshot_q;
`endif

      if (wr_ctrl) begin
         en_d        = data_in[0];
         reload_d    = data_in[1];
         presc_exp_d = (data_in[7:4] > PRESC_MAX) ? PRESC_MAX : data_in[7:4];
`ifdef TIMER_ONESHOT_EN
         oneshot_d   = data_in[2];
`endif
      end
`ifdef TIMER_ONESHOT_EN
      // Auto-stop on the match edge; an explicit CTRL write the same cycle wins
      else if (oneshot_q && hit) begin
         en_d = 1'b0;
      end
`endif

      // A CTRL write or a stopped timer restarts the divide chain from zero
      if (wr_ctrl || !en_q || tick) begin
         presc_d = 16'd0;
      end else begin
         presc_d = presc_q + 16'd1;
      end

      // Flag set takes priority over a same-cycle write-1-to-clear
      match_d = hit || (match_q && !(wr_status && data_in[0]));
      wrap_d  = wrap_evt || (wrap_q && !(wr_status && data_in[1]));

      // CPU commit overrides the tick increment; flags above still use the old count
      if (wr_cnt_hi) begin
         count_d = {data_in, cnt_stage_q};
      end else if (tick) begin
         count_d = (hit && reload_q) ? 16'd0 : count_q + 16'd1;
      end else begin
         count_d = count_q;
      end

      if (wr_cnt_lo) cnt_stage_d = data_in;
      if (wr_cmp_lo) cmp_stage_d = data_in;
      if (wr_cmp_hi) cmp_d       = {data_in, cmp_stage_q};
      // Snapshot the high byte so a LO-then-HI read pair is coherent
      if (rd_cnt_lo) shadow_d    = count_q[15:8];
   end

   // Register update; reset overrides any same-cycle bus activity
   always_ff @(posedge clk) begin
      if (reset) begin
         en_q        <= 1'b0;
         reload_q    <= 1'b0;
         presc_exp_q <= 4'd0;
         match_q     <= 1'b0;
         wrap_q      <= 1'b0;
         count_q     <= 16'd0;
         cmp_q       <= CMP_RESET;
         presc_q     <= 16'd0;
         cnt_stage_q <= 8'd0;
         cmp_stage_q <= 8'd0;
         shadow_q    <= 8'd0;
`ifdef TIMER_ONESHOT_EN
         oneshot_q   <= 1'b0;
`endif
      end else begin
         en_q        <= en_d;
         reload_q    <= reload_d;
         presc_exp_q <= presc_exp_d;
         match_q     <= match_d;
         wrap_q      <= wrap_d;
         count_q     <= count_d;
         cmp_q       <= cmp_d;
         presc_q     <= presc_d;
         cnt_stage_q <= cnt_stage_d;
         cmp_stage_q <= cmp_stage_d;
         shadow_q    <= shadow_d;
`ifdef TIMER_ONESHOT_EN
         oneshot_q   <= oneshot_d;
`endif
      end
   end

   // Combinational read mux, zero latency from the registers
   always_comb begin
      rd_data = 8'h00;
      case (address)
         A_CTRL:   rd_data = {presc_exp_q, 1'b0, oneshot_bit, reload_q, en_q};
         A_STATUS: rd_data = {6'd0, wrap_q, match_q};
         A_CNT_LO: rd_data = count_q[7:0];
         A_CNT_HI: rd_data = shadow_q;
         A_CMP_LO: rd_data = cmp_q[7:0];
         A_CMP_HI: rd_data = cmp_q[15:8];
         default:  rd_data = 8'h00;
      endcase
   end

   assign data_out = bus_rd ? rd_data : 8'hzz;

endmodule

// File: tb/tb_timer_device.sv
// Directed testbench for timer_device: linear sequence of bus writes and
// reads with hand-computed expected values.
module tb_timer_device;

   logic       clk;
   logic       reset;
   logic [3:0] address;
   logic       enable;
   logic       mode;
   logic [7:0] data_in;
   // Idle shared bus is pulled high, so a released bus reads 0xFF
   tri1  [7:0] data_out;

   int checks = 0;
   int errors = 0;

   timer_device #(
      .PRESC_MAX_EXP(15),
      .CMP_RESET(16'hFFFF)
   ) dut (
      .clk(clk),
      .reset(reset),
      .address(address),
      .enable(enable),
      .mode(mode),
      .data_in(data_in),
      .data_out(data_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; the write lands on the following posedge
   task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
      enable  = 1'b1;
      mode    = 1'b1;
      address = a;
      data_in = d;
      @(negedge clk);
      enable  = 1'b0;
      mode    = 1'b0;
      data_in = 8'h00;
   endtask

   // Called at a negedge; samples the combinational read 1 ns later
   task automatic bus_read(input logic [3:0] a, input logic [7:0] exp, input string tag);
      enable  = 1'b1;
      mode    = 1'b0;
      address = a;
      #1;
      check(tag, data_out, exp);
      @(negedge clk);
      enable  = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      reset   = 1'b1;
      enable  = 1'b0;
      mode    = 1'b0;
      address = 4'h0;
      data_in = 8'h00;
      @(negedge clk);
      do_reset();

      // Reset state and released bus
      #1;
      check("idle_bus", data_out, 8'hFF);
      @(negedge clk);
      bus_read(4'h0, 8'h00, "rst_ctrl");
      bus_read(4'h1, 8'h00, "rst_status");
      bus_read(4'h2, 8'h00, "rst_cnt_lo");
      bus_read(4'h3, 8'h00, "rst_cnt_hi");
      bus_read(4'h4, 8'hFF, "rst_cmp_lo");
      bus_read(4'h5, 8'hFF, "rst_cmp_hi");
      bus_write(4'h6, 8'hFF);
      bus_read(4'h6, 8'h00, "unmapped_6");
      bus_read(4'hF, 8'h00, "unmapped_f");
      #1;
      check("idle_bus_after", data_out, 8'hFF);
      @(negedge clk);

      // Free run at PRESC=0: one increment per edge after the CTRL write
      bus_write(4'h0, 8'h01);
      repeat (10) @(negedge clk);
      bus_read(4'h2, 8'h0A, "run10_lo");
      bus_read(4'h3, 8'h00, "run10_hi");
      bus_write(4'h0, 8'h00);
      bus_read(4'h2, 8'h0D, "stopped_lo");
      bus_read(4'h2, 8'h0D, "stopped_hold");

      // Reset wins over a same-cycle CTRL write
      reset   = 1'b1;
      enable  = 1'b1;
      mode    = 1'b1;
      address = 4'h0;
      data_in = 8'h13;
      @(negedge clk);
      reset   = 1'b0;
      enable  = 1'b0;
      mode    = 1'b0;
      bus_read(4'h0, 8'h00, "rst_over_wr_ctrl");
      bus_read(4'h2, 8'h00, "rst_over_wr_cnt");

      // Compare match with reload, PRESC=1 (tick every other cycle)
      bus_write(4'h4, 8'h04);
      bus_write(4'h5, 8'h00);
      bus_read(4'h4, 8'h04, "cmp_lo");
      bus_read(4'h5, 8'h00, "cmp_hi");
      bus_write(4'h0, 8'h13);
      repeat (9) @(negedge clk);
      bus_read(4'h1, 8'h00, "match_before");
      bus_read(4'h1, 8'h01, "match_set");
      bus_read(4'h2, 8'h00, "reload_cnt");
      bus_write(4'h1, 8'h00);
      bus_read(4'h1, 8'h01, "w0_no_clear");
      bus_write(4'h1, 8'h01);
      bus_read(4'h1, 8'h00, "w1c_match");
      bus_write(4'h0, 8'h00);
      bus_read(4'h2, 8'h03, "presc1_cnt");
      bus_read(4'h0, 8'h00, "ctrl_off");

      // Rollover: WRAP flag and coherent LO/HI pair through the shadow
      bus_write(4'h2, 8'hFE);
      bus_write(4'h3, 8'hFF);
      bus_read(4'h2, 8'hFE, "commit_lo");
      bus_read(4'h3, 8'hFF, "commit_hi");
      bus_write(4'h0, 8'h01);
      bus_read(4'h1, 8'h00, "wrap_before");
      bus_read(4'h2, 8'hFF, "roll_lo");
      bus_read(4'h3, 8'hFF, "roll_hi_shadow");
      bus_read(4'h1, 8'h02, "wrap_set");
      bus_write(4'h0, 8'h00);
      bus_read(4'h2, 8'h03, "after_wrap_lo");
      bus_read(4'h3, 8'h00, "after_wrap_hi");
      bus_write(4'h1, 8'h02);
      bus_read(4'h1, 8'h00, "w1c_wrap");

      // COUNT_HI commit on the same edge as a matching tick
      bus_write(4'h2, 8'h04);
      bus_write(4'h3, 8'h00);
      bus_write(4'h2, 8'h34);
      bus_write(4'h0, 8'h01);
      bus_write(4'h3, 8'h12);
      bus_write(4'h0, 8'h00);
      bus_read(4'h1, 8'h01, "commit_tick_match");
      bus_read(4'h2, 8'h35, "commit_tick_lo");
      bus_read(4'h3, 8'h12, "commit_tick_hi");
      bus_write(4'h3, 8'hAB);
      bus_read(4'h2, 8'h34, "stale_stage_lo");
      bus_read(4'h3, 8'hAB, "stale_stage_hi");

      // Flag set beats a same-cycle write-1-to-clear
      bus_write(4'h1, 8'h01);
      bus_read(4'h1, 8'h00, "pre_race_clear");
      bus_write(4'h2, 8'h03);
      bus_write(4'h3, 8'h00);
      bus_write(4'h0, 8'h01);
      @(negedge clk);
      bus_write(4'h1, 8'h01);
      bus_write(4'h0, 8'h00);
      bus_read(4'h1, 8'h01, "set_beats_w1c");
      bus_read(4'h2, 8'h06, "race_cnt");

      // One-shot behaviour (or its absence)
      do_reset();
      bus_write(4'h4, 8'h03);
      bus_write(4'h5, 8'h00);
      bus_write(4'h0, 8'h05);
      repeat (6) @(negedge clk);
`ifdef TIMER_ONESHOT_EN
      bus_read(4'h0, 8'h04, "oneshot_ctrl");
      bus_read(4'h2, 8'h04, "oneshot_cnt");
`else
      bus_read(4'h0, 8'h01, "oneshot_ctrl");
      bus_read(4'h2, 8'h07, "oneshot_cnt");
`endif
      bus_read(4'h1, 8'h01, "oneshot_match");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Hard stop in case the sequence ever stalls
   initial begin
      #200000;
      $display("FAIL timeout: sequence did not complete, required completion");
      $fatal(1, "timeout");
   end

endmodule
